// File: rtl/types_def_pkg.sv
// Shared request/mode types and queue sizing for the TXN controller front end.
package types_def;

  localparam int read_entries      = 16;
  localparam int write_entries     = 16;
  localparam int read_entries_log  = $clog2(read_entries);
  localparam int write_entries_log = $clog2(write_entries);

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic [1:0] {
    RD_MODE    = 2'd0,
    TURN_TO_WR = 2'd1,
    WR_MODE    = 2'd2,
    TURN_TO_RD = 2'd3
  } sched_mode_t;

endpackage

// File: rtl/rw_issue_scheduler_credit_counter.sv
// Outstanding-request credit counter: grant increments, retire decrements,
// a retire with nothing outstanding is ignored and latches a sticky underflow.
module credit_counter #(
  parameter int MAX = 16,
  localparam int CW = $clog2(MAX) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          has_credit,
  output logic          underflow
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          underflow_r;
  logic          underflow_nxt_s;

  // Next count: simultaneous grant and retire cancel out.
  always_comb begin
    count_nxt_s     = count_r;
    underflow_nxt_s = underflow_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r < MAX_C) count_nxt_s = count_r + ONE_C;
        else                 count_nxt_s = count_r;
      end
      2'b01: begin
        if (count_r == '0) underflow_nxt_s = 1'b1;
        else               count_nxt_s     = count_r - ONE_C;
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Count and sticky underflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= '0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign count      = count_r;
  assign has_credit = (count_r < MAX_C);
  assign underflow  = underflow_r;

endmodule

// File: rtl/rw_issue_scheduler.sv
// Read-priority issue scheduler with hysteretic write drain, starvation guard
// and turnaround bubbles on every read/write mode change.
module rw_issue_scheduler
  import types_def::*;
#(
  parameter int RD_MAX       = read_entries,
  parameter int WR_MAX       = write_entries,
  parameter int WR_HIGH_WM   = 12,
  parameter int WR_LOW_WM    = 4,
  parameter int STARVE_LIMIT = 64,
  parameter int TURN_CYCLES  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [write_entries_log:0]   wr_q_count,
  output logic                         out_valid,
  output req_type_t                    out_type,
  input  logic                         out_ready,
  input  logic                         read_done,
  input  logic                         write_done,
  output sched_mode_t                  mode,
  output logic                         underflow
);

  localparam int RCW = $clog2(RD_MAX) + 1;
  localparam int WCW = $clog2(WR_MAX) + 1;
  localparam int QW  = write_entries_log + 1;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam int TW  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  localparam logic [RCW-1:0] RD_LAST_C = RCW'(RD_MAX - 1);
  localparam logic [WCW-1:0] WR_LAST_C = WCW'(WR_MAX - 1);
  localparam logic [QW-1:0]  HIGH_C    = QW'(WR_HIGH_WM);
  localparam logic [QW-1:0]  LOW_C     = QW'(WR_LOW_WM);
  localparam logic [SW-1:0]  STARVE_C  = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]  S_ONE_C   = SW'(1);
  localparam logic [TW-1:0]  TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0]  T_ONE_C   = TW'(1);

  sched_mode_t    mode_r, mode_nxt_s;
  logic [SW-1:0]  starve_r, starve_nxt_s;
  logic [TW-1:0]  turn_r, turn_nxt_s;
  logic           rd_grant_s, wr_grant_s;
  logic           rd_ok_s, wr_ok_s;
  logic           rd_ok_after_s, wr_ok_after_s;
  logic [RCW-1:0] rd_cnt_s;
  logic [WCW-1:0] wr_cnt_s;
  logic           rd_uf_s, wr_uf_s;

  credit_counter #(.MAX(RD_MAX)) u_rd_credit (
    .clk(clk), .rst(rst), .inc(rd_grant_s), .dec(read_done),
    .count(rd_cnt_s), .has_credit(rd_ok_s), .underflow(rd_uf_s)
  );

  credit_counter #(.MAX(WR_MAX)) u_wr_credit (
    .clk(clk), .rst(rst), .inc(wr_grant_s), .dec(write_done),
    .count(wr_cnt_s), .has_credit(wr_ok_s), .underflow(wr_uf_s)
  );

  // State, starvation and turnaround registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r   <= RD_MODE;
      starve_r <= '0;
      turn_r   <= '0;
    end else begin
      mode_r   <= mode_nxt_s;
      starve_r <= starve_nxt_s;
      turn_r   <= turn_nxt_s;
    end
  end

  // Issue slot: only the active mode may offer; turn states are bubbles.
  always_comb begin
    out_valid  = 1'b0;
    out_type   = READ;
    rd_grant_s = 1'b0;
    wr_grant_s = 1'b0;
    case (mode_r)
      RD_MODE: begin
        out_valid  = rd_valid & rd_ok_s;
        out_type   = READ;
        rd_grant_s = rd_valid & rd_ok_s & out_ready;
      end
      WR_MODE: begin
        out_valid  = wr_valid & wr_ok_s;
        out_type   = WRITE;
        wr_grant_s = wr_valid & wr_ok_s & out_ready;
      end
      TURN_TO_WR: out_type = WRITE;
      TURN_TO_RD: out_type = READ;
      default:    out_type = READ;
    endcase
  end

  // Credit availability as it will stand after this cycle's grant and retire.
  always_comb begin
    if (rd_grant_s & ~read_done)      rd_ok_after_s = (rd_cnt_s < RD_LAST_C);
    else if (read_done & ~rd_grant_s) rd_ok_after_s = 1'b1;
    else                              rd_ok_after_s = rd_ok_s;
    if (wr_grant_s & ~write_done)     wr_ok_after_s = (wr_cnt_s < WR_LAST_C);
    else if (write_done & ~wr_grant_s) wr_ok_after_s = 1'b1;
    else                              wr_ok_after_s = wr_ok_s;
  end

  // Starvation age of a waiting write; reaching the limit this cycle counts.
  always_comb begin
    if (wr_grant_s | ~wr_valid)                           starve_nxt_s = '0;
    else if ((mode_r == RD_MODE) && (starve_r != STARVE_C)) starve_nxt_s = starve_r + S_ONE_C;
    else                                                  starve_nxt_s = starve_r;
  end

  // Mode transitions and turnaround bubble counting.
  always_comb begin
    mode_nxt_s = mode_r;
    turn_nxt_s = '0;
    case (mode_r)
      RD_MODE: begin
        if (wr_valid & ((wr_q_count >= HIGH_C) | (starve_nxt_s == STARVE_C) |
                        ~rd_valid | ~rd_ok_after_s))
          mode_nxt_s = TURN_TO_WR;
        else
          mode_nxt_s = RD_MODE;
      end
      TURN_TO_WR: begin
        if (turn_r == TURN_LAST) mode_nxt_s = WR_MODE;
        else begin
          mode_nxt_s = TURN_TO_WR;
          turn_nxt_s = turn_r + T_ONE_C;
        end
      end
      WR_MODE: begin
        if (rd_valid & ((wr_q_count <= LOW_C) | ~wr_valid | ~wr_ok_after_s))
          mode_nxt_s = TURN_TO_RD;
        else
          mode_nxt_s = WR_MODE;
      end
      TURN_TO_RD: begin
        if (turn_r == TURN_LAST) mode_nxt_s = RD_MODE;
        else begin
          mode_nxt_s = TURN_TO_RD;
          turn_nxt_s = turn_r + T_ONE_C;
        end
      end
      default: mode_nxt_s = RD_MODE;
    endcase
  end

  assign rd_ready  = rd_grant_s;
  assign wr_ready  = wr_grant_s;
  assign mode      = mode_r;
  assign underflow = rd_uf_s | wr_uf_s;

endmodule

// File: tb/tb_rw_issue_scheduler.sv
// Directed scoreboard bench: stimulus pushes expected grants (type + cycle),
// a negedge monitor pops and checks every accepted transfer.
module tb_rw_issue_scheduler;
  import types_def::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       rd_valid, wr_valid, out_ready, read_done, write_done;
  logic [write_entries_log:0] wr_q_count;
  logic                       rd_ready, wr_ready, out_valid, underflow;
  req_type_t                  out_type;
  sched_mode_t                mode;

  typedef struct {
    req_type_t typ;
    int        cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t0;

  rw_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_q_count(wr_q_count),
    .out_valid(out_valid), .out_type(out_type), .out_ready(out_ready),
    .read_done(read_done), .write_done(write_done),
    .mode(mode), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted transfer must match the next expected grant.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_grant: type %0d at cycle %0d, required no grant", out_type, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (out_type !== mon_e.typ || cyc != mon_e.cyc ||
            rd_ready !== (mon_e.typ == READ) || wr_ready !== (mon_e.typ == WRITE)) begin
          n_err++;
          $display("FAIL grant: type %0d cycle %0d rd_ready %0b wr_ready %0b, required type %0d cycle %0d",
                   out_type, cyc, rd_ready, wr_ready, mon_e.typ, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic wv, input int qc,
                       input logic ordy, input logic rdn, input logic wdn);
    rd_valid   = rv;
    wr_valid   = wv;
    wr_q_count = qc[write_entries_log:0];
    out_ready  = ordy;
    read_done  = rdn;
    write_done = wdn;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input req_type_t typ, input int c);
    exp_t e;
    e.typ = typ;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mode", int'(mode), int'(RD_MODE));
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_rd_ready", int'(rd_ready), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_out_type", int'(out_type), int'(READ));
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // 1: reads only, credits run out after 16
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      #1;
      if (k < 16) push(READ, t0 + k);
      if (k == 16) begin
        chk("s1_out_valid_full", int'(out_valid), 0);
        chk("s1_rd_ready_full", int'(rd_ready), 0);
      end
      if (k == 19) chk("s1_mode", int'(mode), int'(RD_MODE));
      tick();
    end

    // 2: hysteresis, drain from 12 down to 4
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 24; k++) begin
      drive(k <= 21, k <= 21, (k < 3) ? 11 : (k <= 8) ? 12 : (k <= 16) ? 20 - k : 3,
            1'b1, 1'b0, 1'b0);
      #1;
      if (k <= 3 || k == 21) push(READ, t0 + k);
      if (k >= 8 && k <= 16) push(WRITE, t0 + k);
      if (k == 4)  chk("s2_turn_wr_first", int'(mode), int'(TURN_TO_WR));
      if (k == 5)  chk("s2_bubble_out_valid", int'(out_valid), 0);
      if (k == 7)  chk("s2_turn_wr_last", int'(mode), int'(TURN_TO_WR));
      if (k == 8)  chk("s2_wr_mode", int'(mode), int'(WR_MODE));
      if (k == 16) chk("s2_wr_mode_at_low", int'(mode), int'(WR_MODE));
      if (k == 17) chk("s2_turn_rd_first", int'(mode), int'(TURN_TO_RD));
      if (k == 20) chk("s2_turn_rd_last", int'(mode), int'(TURN_TO_RD));
      if (k == 21) chk("s2_rd_mode", int'(mode), int'(RD_MODE));
      if (k == 23) chk("s2_rd_mode_idle", int'(mode), int'(RD_MODE));
      tick();
    end

    // 3: starvation forces a drain after 64 blocked cycles
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 71; k++) begin
      drive(k <= 68, k <= 68, 2, 1'b1, k < 64, 1'b0);
      #1;
      if (k <= 63) push(READ, t0 + k);
      if (k == 68) push(WRITE, t0 + k);
      if (k == 63) chk("s3_rd_mode_last", int'(mode), int'(RD_MODE));
      if (k == 64) chk("s3_turn_wr", int'(mode), int'(TURN_TO_WR));
      if (k == 65) chk("s3_bubble_out_valid", int'(out_valid), 0);
      if (k == 67) chk("s3_turn_wr_last", int'(mode), int'(TURN_TO_WR));
      if (k == 68) chk("s3_wr_mode", int'(mode), int'(WR_MODE));
      if (k == 69) chk("s3_turn_rd", int'(mode), int'(TURN_TO_RD));
      if (k == 70) chk("s3_underflow", int'(underflow), 0);
      tick();
    end

    // 4: full read credits, retire then regrant, grant+retire together
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 22; k++) begin
      drive(1'b1, 1'b0, 0, 1'b1, (k == 16) || (k == 17), 1'b0);
      #1;
      if (k <= 15 || k == 17 || k == 18) push(READ, t0 + k);
      if (k == 16) chk("s4_blocked_at_16", int'(out_valid), 0);
      if (k == 19) chk("s4_no_17th", int'(out_valid), 0);
      if (k == 21) begin
        chk("s4_still_blocked", int'(out_valid), 0);
        chk("s4_mode", int'(mode), int'(RD_MODE));
      end
      tick();
    end

    // 5: write retire with nothing outstanding
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 24; k++) begin
      if (k == 0) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      else        drive(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
      #1;
      if (k >= 6 && k <= 21) push(WRITE, t0 + k);
      if (k == 1)  chk("s5_underflow_set", int'(underflow), 1);
      if (k == 2)  chk("s5_turn_wr", int'(mode), int'(TURN_TO_WR));
      if (k == 6)  chk("s5_wr_mode", int'(mode), int'(WR_MODE));
      if (k == 22) begin
        chk("s5_wr_credit_limit", int'(out_valid), 0);
        chk("s5_wr_ready_blocked", int'(wr_ready), 0);
        chk("s5_wr_mode_stays", int'(mode), int'(WR_MODE));
      end
      if (k == 23) chk("s5_underflow_sticky", int'(underflow), 1);
      tick();
    end

    // 6: reset in the middle of a write drain
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 32; k++) begin
      rst = (k == 12);
      if (k <= 4)                 drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      else if (k <= 11)           drive(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
      else if (k == 12)           drive(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
      else if (k == 13 || k == 31) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      else                        drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      #1;
      if (k <= 4 || (k >= 14 && k <= 29)) push(READ, t0 + k);
      if (k == 10 || k == 11) push(WRITE, t0 + k);
      if (k == 12) chk("s6_wr_mode_before_rst", int'(mode), int'(WR_MODE));
      if (k == 13) begin
        chk("s6_mode_after_rst", int'(mode), int'(RD_MODE));
        chk("s6_out_valid_after_rst", int'(out_valid), 0);
        chk("s6_underflow_after_rst", int'(underflow), 0);
      end
      if (k == 30) chk("s6_full_16_after_rst", int'(out_valid), 0);
      tick();
    end
    rst = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
